pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the six-stage integer pipeline (pc, if, id, ex, mem1, mem2). It collects hazard and busy requests from each stage and owns the divider start/done handshake. It also sequences exception/eret flushes, including draining an outstanding instruction fetch before restart. It drives the 6-bit stall vector and the `flush` line consumed by every inter-stage register, including the mem1→mem2 register.

---
 rtl/pipeline_stall_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central stall/flush sequencer for the six-stage integer pipeline
// (0:pc 1:if 2:id 3:ex 4:mem1 5:mem2). It merges per-stage hazard/busy
// requests into a stall vector, owns the divider start/done handshake with
// a busy watchdog, and sequences exception/eret flushes. A flush waits for
// an outstanding instruction fetch to drain before pc is redirected.
//
// Optional feature macro: PIPE_CTRL_PERF_EN adds the performance counters
// o_perf_stall_cyc and o_perf_flush_cnt.
//
// Ports:
//   i_clk            clock
//   i_reset          synchronous, active-high reset
//   i_if_miss        icache miss pending (stage 1)
//   i_if_busy        icache bus transaction outstanding
//   i_id_load_use    load-use hazard in id (stage 2)
//   i_ex_is_div      divide op valid in ex (stage 3)
//   i_div_done       divider result valid (1-cycle pulse)
//   i_mem_miss       dcache miss in mem1 (stage 4)
//   i_exc_req        exception/eret commit in mem2
//   i_exc_pc         handler/epc target
//   o_div_start      registered 1-cycle divider launch pulse
//   o_stall          combinational per-stage hold vector
//   o_flush          registered clear of all inter-stage registers
//   o_redirect_valid registered 1-cycle pc load strobe
//   o_redirect_pc    registered restart address
//   o_div_timeout    sticky divider watchdog flag
//   o_perf_stall_cyc cycles with stall[0]=1 (PIPE_CTRL_PERF_EN only)
//   o_perf_flush_cnt flush entries (PIPE_CTRL_PERF_EN only)

module pipeline_stall_ctrl #(
  parameter int unsigned DIV_MAX_CYC = 40
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_miss,
  input  logic        i_if_busy,
  input  logic        i_id_load_use,
  input  logic        i_ex_is_div,
  input  logic        i_div_done,
  input  logic        i_mem_miss,
  input  logic        i_exc_req,
  input  logic [31:0] i_exc_pc,
  output logic        o_div_start,
  output logic [5:0]  o_stall,
  output logic        o_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_div_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] o_perf_stall_cyc,
  output logic [15:0] o_perf_flush_cnt
`endif
);

  localparam int unsigned STAGES = 6;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned CNT_W  = $clog2(DIV_MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DIV_WAIT,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_div_cnt;
  logic [CNT_W-1:0]    w_div_cnt_nxt;
  // Set once the divide in ex has finished (or was abandoned by the
  // watchdog) so the still-present ex_is_div does not relaunch it.
  logic                r_div_fin;
  logic                w_div_fin_nxt;
  logic                r_div_start;
  logic                w_div_start_nxt;
  logic                r_flush;
  logic                w_flush_nxt;
  logic                r_redirect_valid;
  logic                w_redirect_valid_nxt;
  logic [PC_W-1:0]     r_redirect_pc;
  logic [PC_W-1:0]     w_redirect_pc_nxt;
  logic                r_div_timeout;
  logic                w_div_timeout_nxt;
  logic [STAGES-1:0]   w_req;
  logic [STAGES-1:0]   w_stall;

  // Per-stage requests; a bubble goes after the highest requesting stage.
  always_comb begin
    w_req = '0;
    case (r_state)
      ST_RUN: begin
        w_req[1] = i_if_miss;
        w_req[2] = i_id_load_use;
        w_req[3] = i_ex_is_div & ~r_div_fin;
        w_req[4] = i_mem_miss;
      end
      ST_DIV_WAIT: begin
        w_req[1] = i_if_miss;
        w_req[2] = i_id_load_use;
        w_req[3] = 1'b1;
        w_req[4] = i_mem_miss;
      end
      ST_DRAIN: w_req[0] = 1'b1;
      default:  w_req = '0;
    endcase
    // stall[i] is set when any stage at or above i requests.
    for (int i = 0; i < int'(STAGES); i++) begin
      w_stall[i] = |(w_req >> i);
    end
  end

  assign o_stall = w_stall;

  // Next-state and next registered outputs.
  always_comb begin
    w_state_nxt          = r_state;
    w_div_cnt_nxt        = r_div_cnt;
    w_div_fin_nxt        = r_div_fin;
    w_div_start_nxt      = 1'b0;
    w_flush_nxt          = 1'b0;
    w_redirect_valid_nxt = 1'b0;
    w_redirect_pc_nxt    = r_redirect_pc;
    w_div_timeout_nxt    = r_div_timeout;

    if (i_exc_req) begin
      // Exception wins over everything, including a same-cycle div_done.
      w_state_nxt       = ST_FLUSH;
      w_flush_nxt       = 1'b1;
      w_redirect_pc_nxt = i_exc_pc;
      w_div_cnt_nxt     = '0;
      w_div_fin_nxt     = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_div_fin) begin
            // The divide instruction leaves ex once stage 3 is released.
            if (!w_stall[3]) w_div_fin_nxt = 1'b0;
          end else if (i_ex_is_div && !i_mem_miss) begin
            w_state_nxt     = ST_DIV_WAIT;
            w_div_start_nxt = 1'b1;
            w_div_cnt_nxt   = '0;
          end
        end
        ST_DIV_WAIT: begin
          if (i_div_done) begin
            w_state_nxt   = ST_RUN;
            w_div_fin_nxt = 1'b1;
          end else if (r_div_cnt == CNT_LAST) begin
            w_state_nxt       = ST_RUN;
            w_div_fin_nxt     = 1'b1;
            w_div_timeout_nxt = 1'b1;
          end else begin
            w_div_cnt_nxt = r_div_cnt + CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (i_if_busy) begin
            w_state_nxt = ST_DRAIN;
            w_flush_nxt = 1'b1;
          end else begin
            w_state_nxt          = ST_RUN;
            w_redirect_valid_nxt = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (i_if_busy) begin
            w_flush_nxt = 1'b1;
          end else begin
            w_state_nxt          = ST_RUN;
            w_redirect_valid_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  // Registered outputs and divider bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_cnt        <= '0;
      r_div_fin        <= 1'b0;
      r_div_start      <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_div_timeout    <= 1'b0;
    end else begin
      r_div_cnt        <= w_div_cnt_nxt;
      r_div_fin        <= w_div_fin_nxt;
      r_div_start      <= w_div_start_nxt;
      r_flush          <= w_flush_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
      r_div_timeout    <= w_div_timeout_nxt;
    end
  end

  assign o_div_start      = r_div_start;
  assign o_flush          = r_flush;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_div_timeout    = r_div_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall_cyc;
  logic [15:0] r_perf_flush_cnt;

  // Free-running wrapping counters; every exc_req is a FLUSH entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_stall_cyc <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_stall[0]) r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
      if (i_exc_req)  r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
    end
  end

  assign o_perf_stall_cyc = r_perf_stall_cyc;
  assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed test-plan steps
// followed by randomized traffic, all checked against a behavioural model
// built from the stall/flush/divide rules.

module tb_pipeline_stall_ctrl;

  localparam int unsigned DIV_MAX = 40;

  logic        clk;
  logic        reset;
  logic        if_miss, if_busy, id_load_use, ex_is_div, div_done, mem_miss, exc_req;
  logic [31:0] exc_pc;
  logic        div_start, flush, redirect_valid, div_timeout;
  logic [5:0]  stall;
  logic [31:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [15:0] perf_flush_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pipeline_stall_ctrl #(.DIV_MAX_CYC(DIV_MAX)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_if_miss        (if_miss),
    .i_if_busy        (if_busy),
    .i_id_load_use    (id_load_use),
    .i_ex_is_div      (ex_is_div),
    .i_div_done       (div_done),
    .i_mem_miss       (mem_miss),
    .i_exc_req        (exc_req),
    .i_exc_pc         (exc_pc),
    .o_div_start      (div_start),
    .o_stall          (stall),
    .o_flush          (flush),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .o_div_timeout    (div_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .o_perf_stall_cyc (perf_stall_cyc),
    .o_perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the pipeline is doing, not how it is encoded.
  bit          m_flushing;      // in the single flush cycle
  bit          m_draining;      // waiting for the fetch bus to go idle
  bit          m_div_active;    // divider running for the op in ex
  bit          m_div_consumed;  // op in ex already divided, awaiting advance
  int          m_div_age;       // busy cycles spent so far
  logic        e_flush, e_rv, e_start, e_to;
  logic [31:0] e_rpc;
  logic [31:0] e_perf_stall;
  logic [15:0] e_perf_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flushing = 0; m_draining = 0; m_div_active = 0; m_div_consumed = 0; m_div_age = 0;
    e_flush = 0; e_rv = 0; e_start = 0; e_to = 0; e_rpc = '0;
    e_perf_stall = '0; e_perf_flush = '0;
  endtask

  // Highest requesting stage j gives stall = 2^(j+1)-1.
  function automatic logic [5:0] model_stall();
    int j;
    j = -1;
    if (m_flushing) return 6'd0;
    if (m_draining) return 6'd1;
    if (if_miss) j = 1;
    if (id_load_use) j = 2;
    if (m_div_active || (ex_is_div && !m_div_consumed)) j = 3;
    if (mem_miss) j = 4;
    return 6'((32'd1 << (j + 1)) - 32'd1);
  endfunction

  task automatic model_edge();
    logic [5:0] s;
    s = model_stall();
    if (reset) begin
      model_reset();
      return;
    end
    e_start = 0; e_flush = 0; e_rv = 0;
    if (s[0]) e_perf_stall = e_perf_stall + 32'd1;
    if (exc_req) begin
      m_flushing = 1; m_draining = 0; m_div_active = 0; m_div_consumed = 0;
      e_rpc = exc_pc; e_flush = 1;
      e_perf_flush = e_perf_flush + 16'd1;
    end else if (m_flushing) begin
      m_flushing = 0;
      if (if_busy) begin m_draining = 1; e_flush = 1; end
      else e_rv = 1;
    end else if (m_draining) begin
      if (if_busy) e_flush = 1;
      else begin m_draining = 0; e_rv = 1; end
    end else if (m_div_active) begin
      if (div_done) begin
        m_div_active = 0; m_div_consumed = 1;
      end else if (m_div_age + 1 == int'(DIV_MAX)) begin
        m_div_active = 0; m_div_consumed = 1; e_to = 1;
      end else begin
        m_div_age++;
      end
    end else if (m_div_consumed) begin
      if (!s[3]) m_div_consumed = 0;
    end else if (ex_is_div && !mem_miss) begin
      m_div_active = 1; m_div_age = 0; e_start = 1;
    end
  endtask

  // One cycle: inputs already driven after a negedge.
  task automatic tick(input logic [5:0] plan, input bit use_plan);
    #1;
    chk("stall", 32'(stall), 32'(model_stall()));
    if (use_plan) chk("plan_stall", 32'(stall), 32'(plan));
    model_edge();
    @(posedge clk);
    #1;
    chk("flush", 32'(flush), 32'(e_flush));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("div_start", 32'(div_start), 32'(e_start));
    chk("div_timeout", 32'(div_timeout), 32'(e_to));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall_cyc", perf_stall_cyc, e_perf_stall);
    chk("perf_flush_cnt", 32'(perf_flush_cnt), 32'(e_perf_flush));
`endif
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_miss = 0; if_busy = 0; id_load_use = 0; ex_is_div = 0;
    div_done = 0; mem_miss = 0; exc_req = 0; exc_pc = '0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    model_reset();

    // Reset state, then idle.
    tick(6'b000000, 1);
    reset = 0;
    repeat (3) tick(6'b000000, 1);

    // Single load-use bubble.
    id_load_use = 1; tick(6'b000111, 1);
    id_load_use = 0; tick(6'b000000, 1);

    // mem_miss masks the icache miss, then the icache miss alone.
    if_miss = 1; mem_miss = 1; tick(6'b011111, 1);
    mem_miss = 0; tick(6'b000011, 1);
    if_miss = 0; tick(6'b000000, 1);

    // Divide completing 10 cycles after div_start.
    ex_is_div = 1; tick(6'b001111, 1);
    repeat (10) tick(6'b001111, 1);
    div_done = 1; tick(6'b001111, 1);
    div_done = 0; tick(6'b000000, 1);
    ex_is_div = 0; tick(6'b000000, 1);

    // Exception with a 3-cycle fetch drain.
    exc_req = 1; exc_pc = 32'hBFC00380; tick(6'b000000, 1);
    exc_req = 0; exc_pc = '0; if_busy = 1; tick(6'b000000, 1);
    tick(6'b000001, 1);
    tick(6'b000001, 1);
    if_busy = 0; tick(6'b000001, 1);
    chk("plan_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("plan_redirect_pc", redirect_pc, 32'hBFC00380);
    tick(6'b000000, 1);

    // Divider watchdog.
    ex_is_div = 1; tick(6'b001111, 1);
    repeat (DIV_MAX) tick(6'b001111, 1);
    chk("plan_div_timeout", 32'(div_timeout), 32'd1);
    tick(6'b000000, 1);
    ex_is_div = 0; tick(6'b000000, 1);

    // div_done and exc_req together: exception wins.
    ex_is_div = 1; tick(6'b001111, 1);
    repeat (3) tick(6'b001111, 1);
    div_done = 1; exc_req = 1; exc_pc = 32'h8000_0180; tick(6'b001111, 1);
    div_done = 0; exc_req = 0; ex_is_div = 0; tick(6'b000000, 1);
    tick(6'b000000, 1);

    // Reset in the middle of a divide and of a drain.
    ex_is_div = 1; tick(6'b001111, 1);
    repeat (2) tick(6'b001111, 1);
    reset = 1; tick(6'b001111, 1);
    reset = 0; ex_is_div = 0; tick(6'b000000, 1);
    exc_req = 1; exc_pc = 32'h1234_5678; if_busy = 1; tick(6'b000000, 1);
    exc_req = 0; tick(6'b000000, 1);
    tick(6'b000001, 1);
    reset = 1; tick(6'b000001, 1);
    reset = 0; if_busy = 0; tick(6'b000000, 1);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      if_miss     = ($urandom_range(0, 5) == 0);
      if_busy     = ($urandom_range(0, 2) != 0);
      id_load_use = ($urandom_range(0, 6) == 0);
      ex_is_div   = ($urandom_range(0, 3) == 0);
      div_done    = ($urandom_range(0, 19) == 0);
      mem_miss    = ($urandom_range(0, 5) == 0);
      exc_req     = ($urandom_range(0, 39) == 0);
      exc_pc      = $urandom;
      tick(6'b000000, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
